tdm_demux3: RTL and testbench

TDM_DEMUX3 -- requirements
Module: tdm_demux3

---
 rtl/tdm_demux3.sv | 58 +++++
 tb/tb_tdm_demux3.sv | 138 +++++++++++++
 2 files changed

// File: rtl/tdm_demux3.sv
// tdm_demux3: splits a 3-slot TDM stream into registered per-slot words with framing checks
module tdm_demux3 #(
  parameter int k = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [k-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sof,
  output logic [k-1:0] y0,
  output logic [k-1:0] y1,
  output logic [k-1:0] y2,
  output logic [2:0]   exp_slot,
  output logic         frame_valid,
  output logic         sync_err,
  output logic [7:0]   frame_count
);
  localparam logic [1:0] HUNT = 2'd0, S1 = 2'd1, S2 = 2'd2;
  logic [1:0]   state;
  logic [k-1:0] shadow0, shadow1;
  assign exp_slot = state == S1 ? 3'b010 : state == S2 ? 3'b100 : 3'b001;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      shadow0     <= '0;
      shadow1     <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          // an SOF mid-frame abandons the partial frame and restarts at slot 0
          shadow0  <= in_data;
          sync_err <= state != HUNT;
          state    <= S1;
        end else if (state == S1) begin
          shadow1 <= in_data;
          state   <= S2;
        end else if (state == S2) begin
          y0          <= shadow0;
          y1          <= shadow1;
          y2          <= in_data;
          frame_valid <= 1'b1;
          frame_count <= frame_count + 8'd1;
          state       <= HUNT;
        end else begin
          state <= HUNT;
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux3.sv
// tb_tdm_demux3: table-driven scoreboard bench for tdm_demux3
module tb_tdm_demux3;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_sof;
  logic [3:0] in_data, y0, y1, y2;
  logic [2:0] exp_slot;
  logic       frame_valid, sync_err;
  logic [7:0] frame_count;

  tdm_demux3 #(.k(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .y0(y0), .y1(y1), .y2(y2), .exp_slot(exp_slot), .frame_valid(frame_valid),
    .sync_err(sync_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fv, se;
    logic [3:0] a, b, c;
    logic [2:0] sl;
    logic [7:0] n;
  } out_t;

  typedef struct {
    logic       r, v, s;
    logic [3:0] d;
    out_t       e;
  } vec_t;

  int   checks = 0, errors = 0, fv_pulses = 0;
  out_t sb[$];
  vec_t tbl[$];

  function automatic out_t o(logic fv, logic se, logic [3:0] a, logic [3:0] b, logic [3:0] c,
                             logic [2:0] sl, logic [7:0] n);
    return '{fv, se, a, b, c, sl, n};
  endfunction

  function automatic vec_t row(logic r, logic v, logic s, logic [3:0] d, out_t e);
    return '{r, v, s, d, e};
  endfunction

  task automatic step(input logic r, input logic v, input logic s, input logic [3:0] d,
                      input out_t e, input string nm);
    out_t got, want;
    reset = r; in_valid = v; in_sof = s; in_data = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got  = '{frame_valid, sync_err, y0, y1, y2, exp_slot, frame_count};
    want = sb.pop_front();
    checks++;
    if (frame_valid) fv_pulses++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got fv=%0b se=%0b y=%0d/%0d/%0d slot=%b cnt=%0d want fv=%0b se=%0b y=%0d/%0d/%0d slot=%b cnt=%0d",
               nm, got.fv, got.se, got.a, got.b, got.c, got.sl, got.n,
               want.fv, want.se, want.a, want.b, want.c, want.sl, want.n);
    end
  endtask

  initial begin
    logic [3:0] a, b, c, pa, pb, pc;
    logic [7:0] cnt;
    // basic frame
    tbl.push_back(row(1, 0, 0, 0,  o(0, 0, 0, 0, 0, 3'b001, 0)));
    tbl.push_back(row(0, 1, 1, 1,  o(0, 0, 0, 0, 0, 3'b010, 0)));
    tbl.push_back(row(0, 1, 0, 2,  o(0, 0, 0, 0, 0, 3'b100, 0)));
    tbl.push_back(row(0, 1, 0, 4,  o(1, 0, 1, 2, 4, 3'b001, 1)));
    tbl.push_back(row(0, 0, 1, 9,  o(0, 0, 1, 2, 4, 3'b001, 1)));
    // words without sof are dropped in HUNT
    tbl.push_back(row(1, 1, 1, 5,  o(0, 0, 0, 0, 0, 3'b001, 0)));
    tbl.push_back(row(0, 1, 0, 7,  o(0, 0, 0, 0, 0, 3'b001, 0)));
    tbl.push_back(row(0, 1, 0, 9,  o(0, 0, 0, 0, 0, 3'b001, 0)));
    tbl.push_back(row(0, 1, 1, 3,  o(0, 0, 0, 0, 0, 3'b010, 0)));
    tbl.push_back(row(0, 1, 0, 5,  o(0, 0, 0, 0, 0, 3'b100, 0)));
    tbl.push_back(row(0, 1, 0, 6,  o(1, 0, 3, 5, 6, 3'b001, 1)));
    // premature sof in S2
    tbl.push_back(row(1, 0, 0, 0,  o(0, 0, 0, 0, 0, 3'b001, 0)));
    tbl.push_back(row(0, 1, 1, 1,  o(0, 0, 0, 0, 0, 3'b010, 0)));
    tbl.push_back(row(0, 1, 0, 2,  o(0, 0, 0, 0, 0, 3'b100, 0)));
    tbl.push_back(row(0, 1, 1, 8,  o(0, 1, 0, 0, 0, 3'b010, 0)));
    tbl.push_back(row(0, 1, 0, 9,  o(0, 0, 0, 0, 0, 3'b100, 0)));
    tbl.push_back(row(0, 1, 0, 10, o(1, 0, 8, 9, 10, 3'b001, 1)));
    tbl.push_back(row(0, 0, 0, 0,  o(0, 0, 8, 9, 10, 3'b001, 1)));
    // premature sof in S1
    tbl.push_back(row(0, 1, 1, 11, o(0, 0, 8, 9, 10, 3'b010, 1)));
    tbl.push_back(row(0, 1, 1, 12, o(0, 1, 8, 9, 10, 3'b010, 1)));
    tbl.push_back(row(0, 1, 0, 13, o(0, 0, 8, 9, 10, 3'b100, 1)));
    tbl.push_back(row(0, 1, 0, 14, o(1, 0, 12, 13, 14, 3'b001, 2)));
    // gaps of invalid cycles carrying junk
    tbl.push_back(row(1, 0, 0, 0,  o(0, 0, 0, 0, 0, 3'b001, 0)));
    tbl.push_back(row(0, 1, 1, 1,  o(0, 0, 0, 0, 0, 3'b010, 0)));
    tbl.push_back(row(0, 0, 1, 15, o(0, 0, 0, 0, 0, 3'b010, 0)));
    tbl.push_back(row(0, 0, 0, 15, o(0, 0, 0, 0, 0, 3'b010, 0)));
    tbl.push_back(row(0, 1, 0, 2,  o(0, 0, 0, 0, 0, 3'b100, 0)));
    tbl.push_back(row(0, 0, 1, 15, o(0, 0, 0, 0, 0, 3'b100, 0)));
    tbl.push_back(row(0, 0, 0, 15, o(0, 0, 0, 0, 0, 3'b100, 0)));
    tbl.push_back(row(0, 1, 0, 4,  o(1, 0, 1, 2, 4, 3'b001, 1)));
    tbl.push_back(row(0, 0, 0, 15, o(0, 0, 1, 2, 4, 3'b001, 1)));
    // reset mid-frame wins over a valid word, then sof is required again
    tbl.push_back(row(0, 1, 1, 5,  o(0, 0, 1, 2, 4, 3'b010, 1)));
    tbl.push_back(row(0, 1, 0, 6,  o(0, 0, 1, 2, 4, 3'b100, 1)));
    tbl.push_back(row(1, 1, 0, 3,  o(0, 0, 0, 0, 0, 3'b001, 0)));
    tbl.push_back(row(0, 1, 0, 7,  o(0, 0, 0, 0, 0, 3'b001, 0)));
    tbl.push_back(row(0, 1, 0, 8,  o(0, 0, 0, 0, 0, 3'b001, 0)));
    // back-to-back frames
    tbl.push_back(row(0, 1, 1, 1,  o(0, 0, 0, 0, 0, 3'b010, 0)));
    tbl.push_back(row(0, 1, 0, 2,  o(0, 0, 0, 0, 0, 3'b100, 0)));
    tbl.push_back(row(0, 1, 0, 3,  o(1, 0, 1, 2, 3, 3'b001, 1)));
    tbl.push_back(row(0, 1, 1, 4,  o(0, 0, 1, 2, 3, 3'b010, 1)));
    tbl.push_back(row(0, 1, 0, 5,  o(0, 0, 1, 2, 3, 3'b100, 1)));
    tbl.push_back(row(0, 1, 0, 6,  o(1, 0, 4, 5, 6, 3'b001, 2)));
    foreach (tbl[i]) step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));
    // 256 back-to-back frames must wrap the frame counter
    step(1, 0, 0, 0, o(0, 0, 0, 0, 0, 3'b001, 0), "wrap_reset");
    fv_pulses = 0;
    pa = 0; pb = 0; pc = 0; cnt = 0;
    for (int f = 0; f < 256; f++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      step(0, 1, 1, a, o(0, 0, pa, pb, pc, 3'b010, cnt), $sformatf("wrap%0d_s0", f));
      step(0, 1, 0, b, o(0, 0, pa, pb, pc, 3'b100, cnt), $sformatf("wrap%0d_s1", f));
      cnt = cnt + 8'd1;
      step(0, 1, 0, c, o(1, 0, a, b, c, 3'b001, cnt), $sformatf("wrap%0d_s2", f));
      pa = a; pb = b; pc = c;
    end
    checks++;
    if (fv_pulses != 256) begin
      errors++;
      $display("FAIL wrap_pulses got %0d want 256", fv_pulses);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
